// File: rtl/seq_div_16by8_pkg.sv
// Shared definitions for the sequential 16-by-8 restoring divider.
//   N_W       : default dividend / quotient width
//   D_W       : default divisor / remainder width
//   DIV_ITERS : quotient bits resolved per division (one per RUN cycle)
//   div_state_t : controller states
package div_pkg;

    localparam int N_W       = 16;
    localparam int D_W       = 8;
    localparam int DIV_ITERS = N_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_div_16by8_div_step.sv
// One restoring-division iteration, purely combinational.
//   r       in  : partial remainder (D_W+1 bits)
//   q       in  : dividend/quotient shift register
//   divisor in  : denominator
//   r_next  out : partial remainder after this iteration
//   q_next  out : shift register with the new quotient bit in bit 0
// Kept separate so an unrolled or pipelined divider can chain copies of it.
module div_step #(
    parameter int N_W = 16,
    parameter int D_W = 8
) (
    input  logic [D_W:0]   r,
    input  logic [N_W-1:0] q,
    input  logic [D_W-1:0] divisor,
    output logic [D_W:0]   r_next,
    output logic [N_W-1:0] q_next
);

    logic [D_W:0] trial;
    logic         fits;
    // The partial remainder is always below the divisor, so its top bit is
    // zero on entry and only the low D_W bits feed the next trial value.
    logic         unused_r_msb;

    assign unused_r_msb = r[D_W];
    assign trial        = {r[D_W-1:0], q[N_W-1]};
    assign fits         = (trial >= {1'b0, divisor});
    assign r_next       = fits ? (trial - {1'b0, divisor}) : trial;
    assign q_next       = {q[N_W-2:0], fits};

endmodule

// File: rtl/seq_div_16by8.sv
// Sequential restoring divider: N_W-bit dividend / D_W-bit divisor, one
// quotient bit per clock, start/done handshake.
//   clk         in  : clock, rising edge
//   rst_n       in  : synchronous active-low reset
//   start       in  : request a division (ignored while busy)
//   dividend    in  : numerator, captured on the accepting edge
//   divisor     in  : denominator, captured on the accepting edge
//   quotient    out : result, valid from done until the next accepted start
//   remainder   out : remainder, valid with quotient
//   busy        out : high while iterating
//   done        out : one-cycle pulse when results become valid
//   div_by_zero out : set with done for a zero divisor, held until next start
// A zero divisor skips iteration: quotient saturates to all ones and the
// remainder reports the low dividend bits.
module seq_div_16by8 #(
    parameter int N_W = div_pkg::N_W,
    parameter int D_W = div_pkg::D_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    import div_pkg::*;

    localparam int CNT_W = $clog2(N_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);

    div_state_t     state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [D_W:0]   r_reg;
    logic [N_W-1:0] q_reg;
    logic [D_W-1:0] dvs_reg;
    logic [N_W-1:0] quotient_reg;
    logic [D_W-1:0] remainder_reg;
    logic           dbz_reg;

    logic [D_W:0]   r_next;
    logic [N_W-1:0] q_next;

    div_step #(
        .N_W (N_W),
        .D_W (D_W)
    ) u_step (
        .r       (r_reg),
        .q       (q_reg),
        .divisor (dvs_reg),
        .r_next  (r_next),
        .q_next  (q_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            r_reg         <= '0;
            q_reg         <= '0;
            dvs_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    // start is deliberately not looked at here: a request
                    // during iteration is dropped, operands stay intact.
                    r_reg   <= r_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg     <= DONE;
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next[D_W-1:0];
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, which gives
                    // back-to-back operation out of the DONE cycle.
                    if (start) begin
                        dvs_reg <= divisor;
                        q_reg   <= dividend;
                        r_reg   <= '0;
                        cnt_reg <= '0;
                        dbz_reg <= 1'b0;
                        if (divisor == '0) begin
                            state_reg     <= DONE;
                            quotient_reg  <= '1;
                            remainder_reg <= dividend[D_W-1:0];
                            dbz_reg       <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = (state_reg == RUN);
    assign done        = (state_reg == DONE);
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div_16by8.sv
module tb_seq_div_16by8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    seq_div_16by8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain unsigned arithmetic; a zero divisor saturates the
    // quotient and reports the low dividend byte, answered without iterating.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e.acc = 0;
        if (b == 8'd0) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dz  = 1'b1;
            e.lat = 0;
        end else begin
            e.q   = a / {8'd0, b};
            e.r   = 8'(a % {8'd0, b});
            e.dz  = 1'b0;
            e.lat = 16;
        end
        return e;
    endfunction

    // Called at a negedge; the request is taken on the following posedge.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        e = model(a, b);
        e.acc = cyc;
        sb.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        check("busy_after_accept", {31'd0, busy}, {31'd0, (b != 8'd0)});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", {31'd0, done}, 32'd1);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {16'd0, quotient}, {16'd0, e.q});
                    check("remainder", {24'd0, remainder}, {24'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    check("latency", cyc - e.acc - 1, e.lat);
                    check("done_one_cycle", {31'd0, (prev_done && e.lat != 0)}, 32'd0);
                    $display("txn q=%04h r=%02h dz=%0b lat=%0d (exp q=%04h r=%02h dz=%0b lat=%0d)",
                             quotient, remainder, div_by_zero, cyc - e.acc - 1,
                             e.q, e.r, e.dz, e.lat);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        // Reset, with start asserted to show reset has priority.
        dividend = 16'd5;
        divisor  = 8'd1;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'hFFFF, 8'hFF); wait_done(); @(negedge clk);
        issue(16'd1000, 8'd7);  wait_done(); @(negedge clk);
        issue(16'h88EF, 8'hCD); wait_done(); @(negedge clk);

        // Divide by zero: answered immediately, flag held after done drops.
        issue(16'h1234, 8'h00); wait_done();
        @(negedge clk);
        check("dbz_done_drops", {31'd0, done}, 32'd0);
        check("dbz_flag_held", {31'd0, div_by_zero}, 32'd1);
        check("dbz_busy_low", {31'd0, busy}, 32'd0);

        // start during RUN must be ignored; then chain from the DONE cycle.
        issue(16'd50000, 8'd200);
        repeat (4) @(negedge clk);
        dividend = 16'd1;
        divisor  = 8'd1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(16'd40000, 8'd3);
        wait_done();
        @(negedge clk);

        // Abort a division with reset; no done may follow for it.
        dividend = 16'd777;
        divisor  = 8'd9;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {24'd0, remainder}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(16'd100, 8'd10); wait_done(); @(negedge clk);

        // Random operands, occasional zero divisor, mixed back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            issue(a, b);
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
